// File: rtl/writeback_unit.sv
// Writeback stage: commits ALU/load results to an 8 x 16 register file, tracks pending writes, counts retirements.
// Optional feature: define WB_BYPASS_EN for same-cycle write-through on the read and scoreboard ports.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16,
    localparam int RD_W  = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic                   wb_is_ld,
    input  logic [DATA_W+RD_W:0]   rdvalmem,
    input  logic [DATA_W-1:0]      ldresult,
    input  logic [RD_W-1:0]        rs1_addr,
    input  logic [RD_W-1:0]        rs2_addr,
    output logic [DATA_W-1:0]      rs1_data,
    output logic [DATA_W-1:0]      rs2_data,
    input  logic                   busy_set,
    input  logic [RD_W-1:0]        busy_rd,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   wb_we_q,
    output logic [RD_W-1:0]        wb_rd_q,
    output logic [DATA_W-1:0]      wb_data_q,
    output logic [CNT_W-1:0]       retired_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              is_store;
    logic              commit;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] commit_data;

    assign is_store    = rdvalmem[DATA_W+RD_W];
    assign rd          = rdvalmem[RD_W-1:0];
    assign commit      = wb_valid & ~is_store;
    assign commit_data = wb_is_ld ? ldresult : rdvalmem[DATA_W+RD_W-1:RD_W];

    // Clear is applied before set so a same-register set/clear leaves the younger writer pending.
    always_comb begin
        busy_next = busy;
        if (commit)
            busy_next[rd] = 1'b0;
        if (busy_set)
            busy_next[busy_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs        <= '{default: '0};
            busy        <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            retired_cnt <= '0;
        end else begin
            busy    <= busy_next;
            wb_we_q <= commit;
            if (commit) begin
                regs[rd]  <= commit_data;
                wb_rd_q   <= rd;
                wb_data_q <= commit_data;
            end
            if (wb_valid)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
`ifdef WB_BYPASS_EN
        if (commit && rd == rs1_addr) begin
            rs1_data = commit_data;
            rs1_busy = busy_set && busy_rd == rs1_addr;
        end
        if (commit && rd == rs2_addr) begin
            rs2_data = commit_data;
            rs2_busy = busy_set && busy_rd == rs2_addr;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_is_ld = 1'b0;
    logic [19:0] rdvalmem = '0;
    logic [15:0] ldresult = '0;
    logic [2:0]  rs1_addr = '0;
    logic [2:0]  rs2_addr = '0;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        busy_set = 1'b0;
    logic [2:0]  busy_rd = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_we_q;
    logic [2:0]  wb_rd_q;
    logic [15:0] wb_data_q;
    logic [15:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;
    logic        m_we;
    logic [2:0]  m_rd;
    logic [15:0] m_data;
    logic [15:0] m_cnt;

    writeback_unit #(.DATA_W(16), .NREGS(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_is_ld(wb_is_ld),
        .rdvalmem(rdvalmem), .ldresult(ldresult),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .busy_set(busy_set), .busy_rd(busy_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_we_q(wb_we_q), .wb_rd_q(wb_rd_q), .wb_data_q(wb_data_q), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic is_commit();
        return wb_valid && !rdvalmem[19];
    endfunction

    function automatic logic [15:0] wr_data();
        return wb_is_ld ? ldresult : rdvalmem[18:3];
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [2:0] a);
`ifdef WB_BYPASS_EN
        if (is_commit() && rdvalmem[2:0] == a) return wr_data();
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
`ifdef WB_BYPASS_EN
        if (is_commit() && rdvalmem[2:0] == a) return busy_set && busy_rd == a;
`endif
        return m_busy[a];
    endfunction

    // One clock edge; the model applies the rules with the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_busy = '0; m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
        end else begin
            m_we = is_commit();
            if (is_commit()) begin
                m_regs[rdvalmem[2:0]] = wr_data();
                m_rd   = rdvalmem[2:0];
                m_data = wr_data();
                m_busy[rdvalmem[2:0]] = 1'b0;
            end
            if (busy_set) m_busy[busy_rd] = 1'b1;
            if (wb_valid) m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wb_valid = 1'b0; wb_is_ld = 1'b0; busy_set = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [15:0] val,
                         input logic [2:0] rd, input logic [15:0] lres);
        wb_valid = 1'b1; wb_is_ld = ld; rdvalmem = {st, val, rd}; ldresult = lres;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h7777, 3'd1, 16'h0);
        busy_set = 1'b1; busy_rd = 3'd1; rst = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            rs1_addr = 3'(i); rs2_addr = 3'(i); #1;
            checks++;
            if (rs1_data !== 16'h0 || rs2_data !== 16'h0 || rs1_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %h/%h busy %b, expected 0000/0000 busy 0",
                         i, rs1_data, rs2_data, rs1_busy);
            end
        end
        checks++;
        if (retired_cnt !== 16'h0 || wb_we_q !== 1'b0 || wb_rd_q !== 3'd0 || wb_data_q !== 16'h0) begin
            errors++;
            $display("FAIL reset_outs: got cnt %h we %b rd %0d data %h, expected all zero",
                     retired_cnt, wb_we_q, wb_rd_q, wb_data_q);
        end
    endtask

    task automatic test_alu_commit();
        rdvalmem = 20'h12345; wb_valid = 1'b1; wb_is_ld = 1'b0;
        tick();
        idle();
        rs1_addr = 3'd5; #1;
        checks++;
        if (rs1_data !== 16'h2468) begin
            errors++; $display("FAIL alu_commit_data: got %h expected 2468", rs1_data);
        end
        checks++;
        if (wb_we_q !== 1'b1 || wb_rd_q !== 3'd5 || wb_data_q !== 16'h2468 || retired_cnt !== 16'd1) begin
            errors++;
            $display("FAIL alu_commit_regs: got we %b rd %0d data %h cnt %0d, expected 1 5 2468 1",
                     wb_we_q, wb_rd_q, wb_data_q, retired_cnt);
        end
        tick();
        checks++;
        if (wb_we_q !== 1'b0 || wb_rd_q !== 3'd5 || wb_data_q !== 16'h2468 || retired_cnt !== 16'd1) begin
            errors++;
            $display("FAIL idle_hold: got we %b rd %0d data %h cnt %0d, expected 0 5 2468 1",
                     wb_we_q, wb_rd_q, wb_data_q, retired_cnt);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 16'h1111, 3'd3, 16'hBEEF);
        tick();
        idle();
        rs2_addr = 3'd3; #1;
        checks++;
        if (rs2_data !== 16'hBEEF || wb_data_q !== 16'hBEEF) begin
            errors++; $display("FAIL load_commit: got %h / q %h expected BEEF", rs2_data, wb_data_q);
        end
    endtask

    task automatic test_store();
        logic [15:0] cnt_before;
        drive(1'b0, 1'b0, 16'h0011, 3'd2, 16'h0);
        tick();
        cnt_before = m_cnt;
        drive(1'b0, 1'b1, 16'h5555, 3'd2, 16'hAAAA);
        tick();
        idle();
        rs1_addr = 3'd2; #1;
        checks++;
        if (rs1_data !== 16'h0011 || wb_we_q !== 1'b0) begin
            errors++; $display("FAIL store_nowrite: got r2 %h we %b expected 0011 0", rs1_data, wb_we_q);
        end
        checks++;
        if (retired_cnt !== cnt_before + 16'd1 || wb_rd_q !== 3'd2 || wb_data_q !== 16'h0011) begin
            errors++;
            $display("FAIL store_count: got cnt %h rd %0d data %h expected %h 2 0011",
                     retired_cnt, wb_rd_q, wb_data_q, cnt_before + 16'd1);
        end
    endtask

    task automatic test_scoreboard();
        busy_set = 1'b1; busy_rd = 3'd4;
        tick();
        idle();
        rs1_addr = 3'd4; #1;
        checks++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set: got %b expected 1", rs1_busy); end
        drive(1'b0, 1'b0, 16'h0444, 3'd4, 16'h0);
        busy_set = 1'b1; busy_rd = 3'd4;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", rs1_busy); end
        drive(1'b0, 1'b0, 16'h0445, 3'd4, 16'h0);
        busy_set = 1'b1; busy_rd = 3'd1;
        tick();
        idle();
        rs2_addr = 3'd1; #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin
            errors++; $display("FAIL sb_clear_other: got r4 %b r1 %b expected 0 1", rs1_busy, rs2_busy);
        end
        busy_set = 1'b1; busy_rd = 3'd1;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_reset_busy: got %b expected 1", rs2_busy); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_d;
        logic        exp_b;
        busy_set = 1'b1; busy_rd = 3'd6;
        tick();
        drive(1'b0, 1'b0, 16'h00AA, 3'd6, 16'h0);
        busy_set = 1'b0; rs2_addr = 3'd6; #1;
`ifdef WB_BYPASS_EN
        exp_d = 16'h00AA; exp_b = 1'b0;
`else
        exp_d = m_regs[6]; exp_b = 1'b1;
`endif
        checks++;
        if (rs2_data !== exp_d || rs2_busy !== exp_b) begin
            errors++;
            $display("FAIL bypass_read: got %h busy %b expected %h busy %b", rs2_data, rs2_busy, exp_d, exp_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 16'h00AA || rs2_busy !== 1'b0) begin
            errors++; $display("FAIL after_bypass: got %h busy %b expected 00AA 0", rs2_data, rs2_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wb_valid = 1'($urandom); wb_is_ld = 1'($urandom);
            rdvalmem = {($urandom_range(0, 3) == 0), 16'($urandom), 3'($urandom)};
            ldresult = 16'($urandom);
            busy_set = 1'($urandom); busy_rd = 3'($urandom);
            rs1_addr = 3'($urandom); rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 3'($urandom);
            #1;
            checks++;
            if (rs1_data !== exp_rdata(rs1_addr) || rs2_data !== exp_rdata(rs2_addr) ||
                rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
                errors++;
                $display("FAIL rand_read[%0d]: got %h %h %b %b expected %h %h %b %b", n,
                         rs1_data, rs2_data, rs1_busy, rs2_busy, exp_rdata(rs1_addr),
                         exp_rdata(rs2_addr), exp_busy(rs1_addr), exp_busy(rs2_addr));
            end
            tick();
            checks++;
            if (wb_we_q !== m_we || wb_rd_q !== m_rd || wb_data_q !== m_data || retired_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got %b %0d %h %h expected %b %0d %h %h", n,
                         wb_we_q, wb_rd_q, wb_data_q, retired_cnt, m_we, m_rd, m_data, m_cnt);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        int n;
        n = 32'hFFFF - int'(m_cnt);
        drive(1'b0, 1'b1, 16'h0, 3'd0, 16'h0);
        for (int i = 0; i < n; i++) tick();
        idle();
        #1;
        checks++;
        if (retired_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_full: got %h expected FFFF", retired_cnt);
        end
        wb_valid = 1'b1; rdvalmem = 20'h80000;
        tick();
        idle();
        checks++;
        if (retired_cnt !== 16'h0000 || m_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_wrap: got %h expected 0000", retired_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu_commit();
        test_load();
        test_store();
        test_scoreboard();
        test_bypass();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
